// File: rtl/rptr_handler.sv
// Read-domain pointer logic of an asynchronous FIFO.
// Keeps the binary and Gray read pointers and a registered empty flag.
module rptr_handler #(
   parameter int DEPTH     = 16,
   parameter int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 r_en,
   input  logic [PTR_WIDTH:0]   g_wptr_sync,
   output logic [PTR_WIDTH:0]   b_rptr,
   output logic [PTR_WIDTH:0]   g_rptr,
   output logic                 empty
);

   logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d;
   logic [PTR_WIDTH:0] g_rptr_q, g_rptr_d;
   logic               empty_q, empty_d;
   logic               rd;

   // Empty is computed from the next pointer so a read of the last entry
   // raises the flag on the same edge that consumes it.
   always_comb begin
      rd       = r_en & ~empty_q;
      b_rptr_d = b_rptr_q + {{PTR_WIDTH{1'b0}}, rd};
      g_rptr_d = (b_rptr_d >> 1) ^ b_rptr_d;
      empty_d  = (g_rptr_d == g_wptr_sync);
   end

   // rrst_n is active high despite its name.
   always_ff @(posedge rclk or posedge rrst_n) begin
      if (rrst_n) begin
         b_rptr_q <= '0;
         g_rptr_q <= '0;
         empty_q  <= 1'b1;
      end else begin
         b_rptr_q <= b_rptr_d;
         g_rptr_q <= g_rptr_d;
         empty_q  <= empty_d;
      end
   end

   assign b_rptr = b_rptr_q;
   assign g_rptr = g_rptr_q;
   assign empty  = empty_q;

endmodule

// File: tb/tb_rptr_handler.sv
// Bench for rptr_handler: directed scenarios plus randomized traffic,
// checked against an occupancy-based model of the FIFO read side.
module tb_rptr_handler;

   logic       rclk = 1'b0;
   logic       rrst_n = 1'b0;
   logic       r_en = 1'b0;
   logic [4:0] g_wptr_sync = '0;
   logic [4:0] b_rptr, g_rptr;
   logic       empty;

   int checks = 0;
   int errors = 0;

   // Model: read count and write count modulo 32; empty means they match.
   int m_b = 0;
   bit m_e = 1'b1;
   int w_bin = 0;

   rptr_handler #(.DEPTH(16)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
      .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty)
   );

   always #5 rclk = ~rclk;

   function automatic logic [4:0] b2g(int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic set_w(int w);
      w_bin = w % 32;
      g_wptr_sync = b2g(w_bin);
   endtask

   // Advance model by one edge using current inputs, then step the clock.
   task automatic tick();
      bit rd;
      if (rrst_n) begin
         m_b = 0; m_e = 1'b1;
      end else begin
         rd  = r_en && !m_e;
         m_b = (m_b + (rd ? 1 : 0)) % 32;
         m_e = (m_b == w_bin);
      end
      @(posedge rclk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge rclk);
      #1;
      r_en = 1'b1;
      g_wptr_sync = 5'b01000; w_bin = 15;
      #2 rrst_n = 1'b1;
      #1;
      m_b = 0; m_e = 1'b1;
      checks++;
      if (b_rptr !== 5'd0 || g_rptr !== 5'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: b=%0d g=%b e=%b required b=0 g=00000 e=1", b_rptr, g_rptr, empty);
      end
      @(posedge rclk); #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (b_rptr !== 5'd0 || g_rptr !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: b=%0d g=%b e=%b required b=0 g=00000 e=1", b_rptr, g_rptr, empty);
         end
      end
   endtask

   // Expects to be called while reset is asserted.
   task automatic test_drain();
      logic [4:0] eg;
      g_wptr_sync = 5'b01000; w_bin = 15;
      r_en = 1'b1;
      rrst_n = 1'b0;
      tick();
      checks++;
      if (b_rptr !== 5'd0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL drain_first_edge: b=%0d e=%b required b=0 e=0", b_rptr, empty);
      end
      for (int k = 1; k <= 15; k++) begin
         tick();
         eg = b2g(k);
         checks++;
         if (b_rptr !== k[4:0] || g_rptr !== eg || empty !== (k == 15)) begin
            errors++;
            $display("FAIL drain_step%0d: b=%0d g=%b e=%b required b=%0d g=%b e=%0d",
                     k, b_rptr, g_rptr, empty, k, eg, (k == 15));
         end
         if (k == 5) begin
            r_en = 1'b0;
            for (int h = 0; h < 3; h++) begin
               tick();
               checks++;
               if (b_rptr !== 5'd5 || g_rptr !== 5'b00111 || empty !== 1'b0) begin
                  errors++;
                  $display("FAIL hold: b=%0d g=%b e=%b required b=5 g=00111 e=0", b_rptr, g_rptr, empty);
               end
            end
            r_en = 1'b1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (b_rptr !== 5'd15 || g_rptr !== 5'b01000 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_stall: b=%0d g=%b e=%b required b=15 g=01000 e=1", b_rptr, g_rptr, empty);
         end
      end
   endtask

   task automatic test_wrap();
      logic [4:0] prev;
      g_wptr_sync = 5'b11000; w_bin = 16;
      tick();
      checks++;
      if (b_rptr !== 5'd15 || empty !== 1'b0) begin
         errors++;
         $display("FAIL wrap_see_write: b=%0d e=%b required b=15 e=0", b_rptr, empty);
      end
      tick();
      checks++;
      if (b_rptr !== 5'd16 || g_rptr !== 5'b11000 || empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_16: b=%0d g=%b e=%b required b=16 g=11000 e=1", b_rptr, g_rptr, empty);
      end
      set_w(32);
      tick();  // empty drops, no read yet
      for (int k = 17; k <= 32; k++) begin
         prev = g_rptr;
         tick();
         checks++;
         if (b_rptr !== m_b[4:0] || empty !== m_e || $countones(prev ^ g_rptr) != 1) begin
            errors++;
            $display("FAIL wrap_step%0d: b=%0d g=%b prev_g=%b e=%b required b=%0d e=%0d one_bit_change",
                     k, b_rptr, g_rptr, prev, empty, m_b, m_e);
         end
         if (k == 31) begin
            checks++;
            if (g_rptr !== 5'b10000) begin
               errors++;
               $display("FAIL wrap_31: g=%b required 10000", g_rptr);
            end
         end
      end
      checks++;
      if (b_rptr !== 5'd0 || g_rptr !== 5'b00000 || empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_zero: b=%0d g=%b e=%b required b=0 g=00000 e=1", b_rptr, g_rptr, empty);
      end
   endtask

   task automatic test_underflow();
      r_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (b_rptr !== 5'd0 || g_rptr !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow%0d: b=%0d g=%b e=%b required b=0 g=00000 e=1", i, b_rptr, g_rptr, empty);
         end
      end
   endtask

   task automatic test_reset_mid();
      rrst_n = 1'b1;
      tick();
      g_wptr_sync = 5'b01000; w_bin = 15;
      r_en = 1'b1;
      rrst_n = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (b_rptr !== 5'd7) begin
         errors++;
         $display("FAIL mid_setup: b=%0d required 7", b_rptr);
      end
      #2 rrst_n = 1'b1;
      #1;
      m_b = 0; m_e = 1'b1;
      checks++;
      if (b_rptr !== 5'd0 || g_rptr !== 5'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_async: b=%0d g=%b e=%b required b=0 g=00000 e=1", b_rptr, g_rptr, empty);
      end
      tick();
      test_drain();
   endtask

   task automatic test_random();
      int occ;
      rrst_n = 1'b1;
      tick();
      set_w(0);
      rrst_n = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         r_en = ($urandom_range(0, 3) != 0);
         occ = (w_bin - m_b + 32) % 32;
         if ($urandom_range(0, 2) == 0 && occ < 16)
            set_w(w_bin + $urandom_range(1, 16 - occ));
         if ($urandom_range(0, 299) == 0) begin
            rrst_n = 1'b1;
            set_w(0);
         end else begin
            rrst_n = 1'b0;
         end
         tick();
         checks++;
         if (b_rptr !== m_b[4:0] || g_rptr !== b2g(m_b) || empty !== m_e) begin
            errors++;
            $display("FAIL random%0d: b=%0d g=%b e=%b required b=%0d g=%b e=%0d",
                     i, b_rptr, g_rptr, empty, m_b, b2g(m_b), m_e);
         end
      end
      rrst_n = 1'b0;
   endtask

   initial begin
      test_reset();
      test_drain();
      test_wrap();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rptr_handler.md
Name: rptr_handler

Overview:
- Read-side pointer logic of a dual-clock (asynchronous) FIFO, clocked in the read domain.
- Keeps the binary read pointer used to address the FIFO memory and its Gray-coded copy, which is passed to the write domain for synchronization.
- Generates a registered empty flag by comparing the next Gray read pointer with the write pointer already synchronized into the read domain.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- PTR_WIDTH, $clog2(DEPTH) = 4, address width. Pointers are PTR_WIDTH+1 bits; the extra MSB is the wrap bit.

Ports:
- rclk  input  1  read-domain clock; all state updates on the rising edge.
- rrst_n  input  1  asynchronous, active-high reset. The port name is kept from the codebase; it is asserted when 1.
- r_en  input  1  read request from the consumer.
- g_wptr_sync  input  PTR_WIDTH+1  Gray-coded write pointer, already synchronized into rclk.
- b_rptr  output  PTR_WIDTH+1  binary read pointer, registered. Low PTR_WIDTH bits are the memory read address.
- g_rptr  output  PTR_WIDTH+1  Gray-coded read pointer, registered.
- empty  output  1  FIFO empty flag, registered.

Behaviour:
- Reset (rrst_n=1, asynchronous assert, synchronous release on rclk rising edge):
  - b_rptr=0, g_rptr=0, empty=1.
  - Reset has priority over everything and may be asserted at any time, including mid-burst.
- Read qualification: rd = r_en & ~empty. A read request while empty is ignored; no pointer change, no underflow.
- Next-state combinational logic:
  - b_rptr_next = b_rptr + rd, modulo 2^(PTR_WIDTH+1), so it wraps from 2^(PTR_WIDTH+1)-1 to 0.
  - g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next.
  - empty_next = (g_rptr_next == g_wptr_sync), a full-width compare including the wrap bit.
- Each rclk rising edge (not in reset): b_rptr<=b_rptr_next, g_rptr<=g_rptr_next, empty<=empty_next.
- Consistency: g_rptr always equals the Gray code of b_rptr. Only one bit of g_rptr changes per read, including at wrap.
- Latency:
  - A read advances the pointers at the same edge it is accepted.
  - empty reflects that read at the same edge, because it uses the next pointer.
  - A change on g_wptr_sync is reflected in empty one edge later.
- Post-reset empty handling: because empty=1 on leaving reset, the first edge after release performs no read. empty then drops at that edge if g_wptr_sync differs from Gray 0.
- Reading the last entry: when a read makes g_rptr_next equal g_wptr_sync, empty=1 at that same edge. Further r_en is ignored.
- Constant r_en: one read per cycle while not empty.
- r_en=0: pointers hold; empty is still recomputed every edge.
- g_wptr_sync is treated as stable in rclk; no internal synchronizer.
- No latches; every register uses the single asynchronous reset.

Test Plan:
- Reset: assert rrst_n=1 with r_en=1 and g_wptr_sync=5'b01000 -> b_rptr=0, g_rptr=0, empty=1 immediately (asynchronous) and held throughout reset.
- Drain 15 entries: release reset with g_wptr_sync=5'b01000 (binary 15), r_en=1.
  - Edge 1: empty goes to 0, b_rptr stays 0.
  - Edges 2-16: b_rptr steps 1..15; g_rptr goes 00001, 00011, 00010, ... 01000.
  - empty=1 at the edge where b_rptr=15; b_rptr then holds at 15 for all later cycles.
- Hold: in the same drain, drop r_en for 3 cycles at b_rptr=5 -> b_rptr and g_rptr unchanged, empty stays 0; reads resume when r_en returns to 1.
- Wrap-around:
  - From b_rptr=15, set g_wptr_sync=5'b11000 (binary 16) -> one read, b_rptr=16, g_rptr=11000, empty=1.
  - Continue to b_rptr=31 (g_rptr=10000), then to 0 -> g_rptr=00000 with a single-bit change.
  - empty tracks the full-width equality with g_wptr_sync throughout.
- Underflow: with empty=1 and r_en=1 held for 10 cycles and g_wptr_sync unchanged -> no pointer movement.
- Reset mid-operation: assert rrst_n=1 at b_rptr=7 -> pointers go to 0 and empty goes to 1 asynchronously. After release, the drain-15 sequence repeats exactly.
